// File: rtl/sha256_pkg.sv
// SHA-256 shared package: word/block sizes, round count,
// and the message-schedule control state encoding.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int ROUNDS      = 64;

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_e;

endpackage

// File: rtl/sha256_sigma.sv
// SHA-256 small sigma functions, purely combinational.
// Ports: x (word in), y (sigma(x)).
module sha256_sigma0
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  assign y = {x[6:0], x[31:7]}
           ^ {x[17:0], x[31:18]}
           ^ (x >> 3);

endmodule

module sha256_sigma1
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  assign y = {x[16:0], x[31:17]}
           ^ {x[18:0], x[31:19]}
           ^ (x >> 10);

endmodule

// File: rtl/sha256_wbuf.sv
// 16x32 schedule buffer: one write port, four async reads.
// Ports: clk, we/waddr/wdata (write), ra0..ra3 -> rd0..rd3.
module sha256_wbuf
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [3:0]        ra0,
  input  logic [3:0]        ra1,
  input  logic [3:0]        ra2,
  input  logic [3:0]        ra3,
  output logic [WORD_W-1:0] rd0,
  output logic [WORD_W-1:0] rd1,
  output logic [WORD_W-1:0] rd2,
  output logic [WORD_W-1:0] rd3
);

  logic [WORD_W-1:0] mem_q [BLOCK_WORDS];
  logic [WORD_W-1:0] mem_d [BLOCK_WORDS];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd0 = mem_q[ra0];
  assign rd1 = mem_q[ra1];
  assign rd2 = mem_q[ra2];
  assign rd3 = mem_q[ra3];

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads W0..W15, emits W0..W63.
// Ports: in_* (loader handshake), w_* (round handshake), busy, done.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = ROUNDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_word,
  output logic [5:0]        w_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  t_q, t_d;
  logic        done_q, done_d;

  logic        in_acc, w_acc, expand;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic [WORD_W-1:0] rd_m2, rd_m7, rd_m15, rd_m16;
  logic [WORD_W-1:0] s0, s1, w_sum;

  assign in_acc = (state_q == ST_LOAD) && in_valid;
  assign w_acc  = (state_q == ST_RUN) && w_ready;
  assign expand = (t_q[5:4] != 2'b00);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      t_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      done_q  <= done_d;
    end
  end

  // Next-state and counters
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        if (in_acc) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = ST_RUN;
            t_d     = '0;
          end
        end
      end
      ST_RUN: begin
        if (w_acc) begin
          t_d = t_q + 6'd1;
          if (t_q == LAST_T) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            t_d     = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready = (state_q == ST_LOAD);
    busy     = (state_q == ST_RUN);
    w_valid  = (state_q == ST_RUN);
    w_idx    = t_q;
    done     = done_q;
    w_word   = '0;
    if (state_q == ST_RUN) w_word = expand ? w_sum : rd_m16;
  end

  // Buffer write: loader words in LOAD, expanded words in RUN
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cnt_q;
    wr_data = in_word;
    if (state_q == ST_LOAD) begin
      wr_en = in_acc;
    end else begin
      wr_en   = w_acc && expand;
      wr_addr = t_q[3:0];
      wr_data = w_sum;
    end
  end

  // t-16 aliases t mod 16; t-15 aliases t+1.
  sha256_wbuf u_wbuf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .ra0   (t_q[3:0] - 4'd2),
    .ra1   (t_q[3:0] - 4'd7),
    .ra2   (t_q[3:0] + 4'd1),
    .ra3   (t_q[3:0]),
    .rd0   (rd_m2),
    .rd1   (rd_m7),
    .rd2   (rd_m15),
    .rd3   (rd_m16)
  );

  sha256_sigma0 u_s0 (.x(rd_m15), .y(s0));
  sha256_sigma1 u_s1 (.x(rd_m2),  .y(s1));

  assign w_sum = s1 + rd_m7 + s0 + rd_m16;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Randomized bench for sha256_msg_sched against a
// full-array FIPS 180-4 schedule model.
module tb_sha256_msg_sched;

  localparam int NR = 64;

  typedef logic [31:0] blk_t [16];

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_word;
  logic [5:0]  w_idx;
  logic        busy;
  logic        done;

  int n_chk;
  int n_err;
  logic [31:0] seen_w [NR];

  sha256_msg_sched #(.NUM_ROUNDS(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_word   (w_word),
    .w_idx    (w_idx),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x,
                                       input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference: straightforward 64-entry schedule array.
  function automatic void ref_sched(input blk_t m,
                                    output logic [31:0] w [NR]);
    for (int t = 0; t < NR; t++) begin
      if (t < 16) w[t] = m[t];
      else w[t] = ssig1(w[t-2]) + w[t-7]
                + ssig0(w[t-15]) + w[t-16];
    end
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_w_valid"},  32'(w_valid),  32'd0);
    chk({tag, "_w_word"},   w_word,        32'd0);
    chk({tag, "_w_idx"},    32'(w_idx),    32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
  endtask

  // Loads one block, then drains it. gaps: random in_valid
  // bubbles; bp: random w_ready; hold: in_valid high in RUN;
  // rst_at: assert reset when that index is presented (-1 none).
  task automatic run_block(input blk_t m, input bit gaps,
                           input bit bp, input bit hold,
                           input int rst_at);
    logic [31:0] ref_w [NR];
    int k;
    int budget;
    bit take;
    ref_sched(m, ref_w);
    for (int i = 0; i < 16; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        w_ready  = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_word  = m[i];
      w_ready  = 1'($urandom);
      chk("load_in_ready", 32'(in_ready), 32'd1);
      chk("load_w_valid",  32'(w_valid),  32'd0);
      @(posedge clk); #1;
    end
    in_valid = hold;
    in_word  = $urandom;
    k = 0;
    budget = 0;
    while (k < NR) begin
      if (budget > 1000) begin
        chk("run_timeout", 32'(k), 32'(NR));
        return;
      end
      budget++;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        #2;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("post_rst");
        return;
      end
      chk("run_w_valid",  32'(w_valid),  32'd1);
      chk("run_in_ready", 32'(in_ready), 32'd0);
      chk("run_busy",     32'(busy),     32'd1);
      chk("run_done",     32'(done),     32'd0);
      chk("run_w_idx",    32'(w_idx),    32'(k));
      chk("run_w_word",   w_word,        ref_w[k]);
      seen_w[k] = w_word;
      take = bp ? 1'($urandom) : 1'b1;
      w_ready = take;
      if (hold) in_word = $urandom;
      @(posedge clk); #1;
      if (take) k++;
    end
    w_ready = 1'b0;
    chk("end_done",     32'(done),     32'd1);
    chk("end_in_ready", 32'(in_ready), 32'd1);
    chk("end_busy",     32'(busy),     32'd0);
    chk("end_w_valid",  32'(w_valid),  32'd0);
    if (!hold) begin
      @(posedge clk); #1;
      chk("done_once", 32'(done), 32'd0);
    end
  endtask

  blk_t b;
  blk_t b2;

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    w_ready  = 1'b0;
    in_word  = '0;
    #1;
    chk_reset_vals("reset");
    #11;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("reset_rel");

    // "abc" padded block
    foreach (b[i]) b[i] = '0;
    b[0]  = 32'h61626380;
    b[15] = 32'h00000018;
    run_block(b, 1'b0, 1'b0, 1'b0, -1);
    chk("abc_w0",  seen_w[0],  32'h61626380);
    chk("abc_w15", seen_w[15], 32'h00000018);
    chk("abc_w16", seen_w[16], 32'h61626380);
    chk("abc_w17", seen_w[17], 32'h000F0000);

    // sigma1 path only
    foreach (b[i]) b[i] = '0;
    b[14] = 32'h00000001;
    run_block(b, 1'b0, 1'b0, 1'b0, -1);
    chk("s1_w16", seen_w[16], 32'h0000A000);

    // All ones: heavy carry wrap
    foreach (b[i]) b[i] = 32'hFFFFFFFF;
    run_block(b, 1'b0, 1'b0, 1'b0, -1);

    // Random blocks with back-pressure and load bubbles
    for (int n = 0; n < 3; n++) begin
      foreach (b[i]) b[i] = $urandom;
      run_block(b, 1'b1, 1'b1, 1'b0, -1);
    end

    // Back-to-back blocks, in_valid held high
    foreach (b[i])  b[i]  = $urandom;
    foreach (b2[i]) b2[i] = $urandom;
    run_block(b, 1'b0, 1'b0, 1'b1, -1);
    run_block(b2, 1'b0, 1'b0, 1'b0, -1);

    // Reset mid-RUN, then a fresh block
    foreach (b[i]) b[i] = $urandom;
    run_block(b, 1'b0, 1'b0, 1'b0, 30);
    foreach (b[i]) b[i] = $urandom;
    run_block(b, 1'b1, 1'b1, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
